// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Pipeline-side hazard inputs and the stall/flush controls
//                returned by the hazard scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [4:0] ex_reg_dst;
  logic       ex_memread;
  logic       muldiv_start;
  logic       muldiv_is_div;
  logic       dmem_req;
  logic       dmem_ready;
  logic       exc_req;
  logic       pc_stall;
  logic       IF_stall;
  logic       IF_flush;
  logic       ID_stall;
  logic       ID_flush;
  logic       EX_stall;
  logic       muldiv_busy;
  logic       muldiv_done;
  logic [1:0] state_dbg;

  // Scheduler side: consumes hazard sources, produces controls
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_reg_dst, ex_memread,
           muldiv_start, muldiv_is_div, dmem_req, dmem_ready, exc_req,
    output pc_stall, IF_stall, IF_flush, ID_stall, ID_flush, EX_stall,
           muldiv_busy, muldiv_done, state_dbg
  );

  // Pipeline side: presents hazard sources, obeys controls
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_reg_dst, ex_memread,
           muldiv_start, muldiv_is_div, dmem_req, dmem_ready, exc_req,
    input  pc_stall, IF_stall, IF_flush, ID_stall, ID_flush, EX_stall,
           muldiv_busy, muldiv_done, state_dbg
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Stall/flush scheduler for the 5-stage MIPS32 pipeline.
//                Resolves memory waits, mult/div EX occupancy, exception
//                flushes and load-use hazards into one set of controls.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MUL_LAT      = 4,
  parameter int DIV_LAT      = 34,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MULDIV = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  // Counter preloads: the start cycle and the final (done) cycle are not
  // counted, hence LAT-2 for mult/div.
  localparam logic [5:0] C_MUL_INIT   = 6'(MUL_LAT - 2);
  localparam logic [5:0] C_DIV_INIT   = 6'(DIV_LAT - 2);
  localparam logic [5:0] C_FLUSH_INIT = 6'(FLUSH_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       exc_pend_q, exc_pend_d;

  logic w_mem_wait;
  logic w_load_use;
  logic w_md_start;
  logic w_cnt_zero;
  logic w_ex_stall;
  logic w_id_stall;

  assign w_mem_wait = hz.dmem_req & ~hz.dmem_ready;
  assign w_load_use = hz.ex_memread & (hz.ex_reg_dst != 5'd0) &
                      ((hz.id_uses_rs & (hz.id_rs == hz.ex_reg_dst)) |
                       (hz.id_uses_rt & (hz.id_rt == hz.ex_reg_dst)));
  // A pending or arriving exception outranks launching a new mult/div
  assign w_md_start = hz.muldiv_start & ~exc_pend_q & ~hz.exc_req;
  assign w_cnt_zero = (cnt_q == 6'd0);
  // EX freeze: memory wait anywhere, mult/div launch, or mult/div still running
  assign w_ex_stall = w_mem_wait |
                      ((state_q == S_IDLE)   & w_md_start) |
                      ((state_q == S_MULDIV) & ~w_cnt_zero);

  // State, counter and pending-exception registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      exc_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      exc_pend_q <= exc_pend_d;
    end
  end

  // Next-state, counter and exception-pending logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    exc_pend_d = exc_pend_q;
    case (state_q)
      S_IDLE: begin
        if (w_md_start) begin
          cnt_d   = hz.muldiv_is_div ? C_DIV_INIT : C_MUL_INIT;
          state_d = S_MULDIV;
        end else if ((hz.exc_req | exc_pend_q) & ~w_mem_wait) begin
          cnt_d   = C_FLUSH_INIT;
          state_d = S_FLUSH;
        end
      end
      S_MULDIV: begin
        if (!w_cnt_zero) begin
          cnt_d = cnt_q - 6'd1;
        end else if (exc_pend_q) begin
          cnt_d   = C_FLUSH_INIT;
          state_d = S_FLUSH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        // Flush progress is held off while memory freezes the pipe
        if (!w_mem_wait) begin
          if (w_cnt_zero) begin
            state_d    = S_IDLE;
            exc_pend_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
    // An exception that arrives while EX is frozen is remembered until served
    if (hz.exc_req & w_ex_stall) exc_pend_d = 1'b1;
  end

  // Output decode; every control is forced low while reset is asserted
  always_comb begin
    hz.pc_stall    = 1'b0;
    hz.IF_stall    = 1'b0;
    hz.IF_flush    = 1'b0;
    hz.ID_stall    = 1'b0;
    hz.ID_flush    = 1'b0;
    hz.EX_stall    = 1'b0;
    hz.muldiv_busy = 1'b0;
    hz.muldiv_done = 1'b0;
    hz.state_dbg   = 2'd0;
    w_id_stall     = 1'b0;
    if (rst_n) begin
      hz.EX_stall    = w_ex_stall;
      hz.muldiv_busy = (state_q == S_MULDIV);
      hz.muldiv_done = (state_q == S_MULDIV) & w_cnt_zero;
      hz.state_dbg   = state_q;
      if (state_q == S_FLUSH) begin
        // ID instruction is squashed, so load-use is moot here
        w_id_stall  = w_ex_stall;
        hz.IF_flush = ~w_ex_stall;
        hz.ID_flush = ~w_ex_stall;
      end else begin
        w_id_stall  = w_load_use | w_ex_stall;
      end
      hz.ID_stall = w_id_stall;
      hz.IF_stall = w_id_stall;
      hz.pc_stall = w_id_stall;
    end
  end

endmodule
`default_nettype wire
